// File: rtl/sqrt_arbiter_pkg.sv
// Shared types and constants for the sqrt core arbiter slice.
// Optional watchdog is enabled by defining SQRT_ARB_TIMEOUT_EN.
package sqrt_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int          RADICAND_W = 32;
    localparam int          ROOT_W     = 16;
    localparam logic [15:0] ERR_ROOT   = 16'hFFFF;

endpackage

// File: rtl/sqrt_arbiter_if.sv
// Request/response bundle between the channel delay calculators and the arbiter.
// The arbiter connects through the slave modport, the requester side through master.
interface sqrt_arbiter_if
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*RADICAND_W-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [ROOT_W-1:0]           rsp_data;
    logic                        rsp_err;

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/sqrt_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
// The pointer itself lives in the parent so it can be updated only on an actual grant.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);
    logic            w_found;
    logic [ID_W-1:0] w_cand;

    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        o_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = ID_W'((int'(i_ptr) + k) % N_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_idx   = w_cand;
            end
        end
        o_grant = w_found ? (N_REQ'(1) << o_idx) : '0;
        o_any   = |i_req;
    end
endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one iterative sqrt core among N_REQ requesters with round-robin arbitration.
// Define SQRT_ARB_TIMEOUT_EN to add a RUN-state watchdog that aborts with rsp_err=1.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    sqrt_arbiter_if.slave         io_bus,
    output logic                  o_core_enable,
    output logic                  o_core_reset,
    output logic [RADICAND_W-1:0] o_core_din,
    input  logic [ROOT_W-1:0]     i_core_dout,
    input  logic                  i_core_valid
);
    if (N_REQ < 2 || N_REQ > 16 || ID_W != $clog2(N_REQ) || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("sqrt_arbiter: unsupported N_REQ/ID_W/TIMEOUT_CYC combination");
    end

    state_t                r_state;
    logic [ID_W-1:0]       r_ptr;
    logic [N_REQ-1:0]      r_req_ready;
    logic                  r_rsp_valid;
    logic [ID_W-1:0]       r_rsp_id;
    logic [ROOT_W-1:0]     r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_core_enable;
    logic                  r_core_reset;
    logic [RADICAND_W-1:0] r_core_din;
    logic                  r_core_valid_q;

    logic [N_REQ-1:0]      w_grant;
    logic [ID_W-1:0]       w_idx;
    logic                  w_any;
    logic [RADICAND_W-1:0] w_din_sel;
    logic                  w_done_edge;
    logic [ID_W-1:0]       w_ptr_next;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] r_cnt;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .i_req   (io_bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_din_sel   = io_bus.req_data[RADICAND_W*int'(w_idx) +: RADICAND_W];
    assign w_done_edge = i_core_valid & ~r_core_valid_q;
    assign w_ptr_next  = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_req_ready    <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_core_enable  <= 1'b0;
            r_core_reset   <= 1'b0;
            r_core_din     <= '0;
            r_core_valid_q <= 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
            r_cnt          <= '0;
`endif
        end else begin
            r_core_valid_q <= i_core_valid;
            r_core_reset   <= 1'b0;
            r_req_ready    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_core_reset <= 1'b1;
                        r_state      <= S_GRANT;
                    end
                end
                // Requesters hold req_valid until they see req_ready, so the pick here
                // normally finds someone; fall back to IDLE if they all withdrew.
                S_GRANT: begin
                    if (w_any) begin
                        r_req_ready   <= w_grant;
                        r_core_din    <= w_din_sel;
                        r_rsp_id      <= w_idx;
                        r_ptr         <= w_ptr_next;
                        r_core_enable <= 1'b1;
                        r_state       <= S_RUN;
`ifdef SQRT_ARB_TIMEOUT_EN
                        r_cnt         <= '0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_done_edge) begin
                        r_core_enable <= 1'b0;
                        r_rsp_data    <= i_core_dout;
                        r_rsp_err     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
`ifdef SQRT_ARB_TIMEOUT_EN
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYC)) begin
                        r_core_reset  <= 1'b1;
                        r_core_enable <= 1'b0;
                        r_rsp_data    <= ERR_ROOT;
                        r_rsp_err     <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (io_bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.req_ready = r_req_ready;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_id    = r_rsp_id;
    assign io_bus.rsp_data  = r_rsp_data;
    assign io_bus.rsp_err   = r_rsp_err;
    assign o_core_enable    = r_core_enable;
    assign o_core_reset     = r_core_reset;
    assign o_core_din       = r_core_din;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: floor-sqrt core stub plus a queue-based round-robin reference model.
// The watchdog scenario is included only when SQRT_ARB_TIMEOUT_EN is defined.
module tb_sqrt_arbiter;
    import sqrt_arb_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sqrt_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus ();

    logic        core_enable, core_reset;
    logic [31:0] core_din;
    logic [15:0] core_dout = '0;
    logic        core_valid = 1'b0;

    sqrt_arbiter #(.N_REQ(N), .ID_W(IW), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_bus        (bus),
        .o_core_enable (core_enable),
        .o_core_reset  (core_reset),
        .o_core_din    (core_din),
        .i_core_dout   (core_dout),
        .i_core_valid  (core_valid)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'(1) << b);
            if (32'(t) * 32'(t) <= x) r = t;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // requester side: a channel requests while issued != served
    int          issued[N];
    int          served[N];
    logic [31:0] pdata[N];
    logic        rsp_ready_tb = 1'b1;
    logic        stub_hang = 1'b0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]           = (issued[i] != served[i]);
            bus.req_data[32*i +: 32]   = pdata[i];
        end
    end
    assign bus.rsp_ready = rsp_ready_tb;

    // core stub: valid rises 10 cycles after enable, cleared by core_reset
    int stub_cnt = 0;
    always @(posedge clk) begin
        if (core_reset || reset) begin
            core_valid <= 1'b0;
            stub_cnt   <= 0;
        end else if (core_enable && !core_valid && !stub_hang) begin
            if (stub_cnt == 9) begin
                core_valid <= 1'b1;
                core_dout  <= isqrt(core_din);
            end
            stub_cnt <= stub_cnt + 1;
        end
    end

    // reference model
    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    int          mptr = 0;
    logic [N-1:0] snap_req;
    logic [31:0] snap_data[N];
    logic [31:0] cur_din = '0;
    logic        hold = 1'b0;
    logic [IW-1:0] h_id;
    logic [15:0] h_data;
    logic        h_err;
    int          hs_n = 0;
    int          log_id[$];
    int          log_data[$];
    int          log_err[$];

    always @(posedge clk) begin
        snap_req <= bus.req_valid;
        for (int i = 0; i < N; i++) snap_data[i] <= pdata[i];
    end

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            mptr = 0;
            hold = 1'b0;
            for (int i = 0; i < N; i++) served[i] = issued[i];
        end else begin
            if (bus.req_ready != '0) begin
                int g;
                int a;
                exp_t e;
                g = rr_pick(snap_req, mptr);
                a = 0;
                for (int i = 0; i < N; i++) if (bus.req_ready[i]) a = i;
                chk("grant_onehot", 64'(bus.req_ready), (g < 0) ? 64'd0 : 64'd1 << g);
                chk("grant_while_rsp", 64'(bus.rsp_valid), 64'd0);
                e.id   = a;
                e.data = stub_hang ? 16'hFFFF : isqrt(snap_data[a]);
                e.err  = stub_hang;
                expq.push_back(e);
                cur_din = snap_data[a];
                mptr = (a + 1) % N;
                served[a] = issued[a];
            end
            if (core_enable) chk("core_din_stable", 64'(core_din), 64'(cur_din));
            if (bus.rsp_valid) begin
                if (hold) begin
                    chk("rsp_hold_id", 64'(bus.rsp_id), 64'(h_id));
                    chk("rsp_hold_data", 64'(bus.rsp_data), 64'(h_data));
                    chk("rsp_hold_err", 64'(bus.rsp_err), 64'(h_err));
                end
                if (bus.rsp_ready) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected id=%0d data=%0h expected no response", bus.rsp_id, bus.rsp_data);
                    end else begin
                        exp_t e;
                        e = expq.pop_front();
                        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                        chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    end
                    log_id.push_back(int'(bus.rsp_id));
                    log_data.push_back(int'(bus.rsp_data));
                    log_err.push_back(int'(bus.rsp_err));
                    hs_n++;
                    hold = 1'b0;
                end else begin
                    hold   = 1'b1;
                    h_id   = bus.rsp_id;
                    h_data = bus.rsp_data;
                    h_err  = bus.rsp_err;
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    task automatic issue(input int ch, input logic [31:0] d);
        pdata[ch]  = d;
        issued[ch] = issued[ch] + 1;
    endtask

    task automatic wait_hs(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (hs_n < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 64'(hs_n >= n), 64'd1);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({nm, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({nm, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
        chk({nm, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
        chk({nm, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        chk({nm, "_core_enable"}, 64'(core_enable), 64'd0);
        chk({nm, "_core_reset"}, 64'(core_reset), 64'd0);
        chk({nm, "_core_din"}, 64'(core_din), 64'd0);
    endtask

    initial begin
        int n;
        int base;
        int seen;
        for (int i = 0; i < N; i++) begin
            issued[i] = 0;
            pdata[i]  = '0;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // T1: single request, latency and result
        issue(0, 32'd144);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready[0] && n < 10);
        chk("t1_latency", 64'(n), 64'd2);
        wait_hs(1, 60, "t1_hs_timeout");
        chk("t1_id", 64'(log_id[0]), 64'd0);
        chk("t1_data", 64'(log_data[0]), 64'd12);
        chk("t1_err", 64'(log_err[0]), 64'd0);

        // T5: reset in RUN discards the job
        issue(2, 32'd50);
        n = 0;
        while (!bus.req_ready[2] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t5_granted", 64'(bus.req_ready[2]), 64'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle_outputs("t5_reset");
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("t5_no_rsp", 64'(seen), 64'd0);

        // T2: all four at once from pointer 0
        base = hs_n;
        issue(0, 32'd1);
        issue(1, 32'd4);
        issue(2, 32'd9);
        issue(3, 32'd16);
        wait_hs(base + 4, 200, "t2_hs_timeout");
        for (int i = 0; i < 4; i++) begin
            chk("t2_id", 64'(log_id[base + i]), 64'(i));
            chk("t2_data", 64'(log_data[base + i]), 64'(i + 1));
        end

        // T3: move pointer to 2, then ch1+ch3 -> ch3 first
        base = hs_n;
        issue(1, 32'd25);
        wait_hs(base + 1, 60, "t3a_hs_timeout");
        issue(1, 32'd36);
        issue(3, 32'd49);
        wait_hs(base + 3, 120, "t3_hs_timeout");
        chk("t3_first_id", 64'(log_id[base + 1]), 64'd3);
        chk("t3_first_data", 64'(log_data[base + 1]), 64'd7);
        chk("t3_second_id", 64'(log_id[base + 2]), 64'd1);
        chk("t3_second_data", 64'(log_data[base + 2]), 64'd6);

        // T4: backpressure holds response and blocks new grants
        base = hs_n;
        @(posedge clk);
        #2 rsp_ready_tb = 1'b0;
        issue(0, 32'd10000);
        issue(2, 32'd65535);
        n = 0;
        while (!bus.rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("t4_rsp_seen", 64'(bus.rsp_valid), 64'd1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.req_ready != '0 || !bus.rsp_valid || bus.rsp_data != 16'd255) seen++;
        end
        chk("t4_stall_clean", 64'(seen), 64'd0);
        @(posedge clk);
        #2 rsp_ready_tb = 1'b1;
        wait_hs(base + 2, 120, "t4_hs_timeout");
        chk("t4_first_id", 64'(log_id[base]), 64'd2);
        chk("t4_first_data", 64'(log_data[base]), 64'd255);
        chk("t4_second_id", 64'(log_id[base + 1]), 64'd0);
        chk("t4_second_data", 64'(log_data[base + 1]), 64'd100);

        // T7: extreme radicands, pointer at 1 -> ch3 then ch0
        base = hs_n;
        issue(0, 32'd0);
        issue(3, 32'hFFFF_FFFF);
        wait_hs(base + 2, 120, "t7_hs_timeout");
        chk("t7_max_id", 64'(log_id[base]), 64'd3);
        chk("t7_max_data", 64'(log_data[base]), 64'hFFFF);
        chk("t7_zero_id", 64'(log_id[base + 1]), 64'd0);
        chk("t7_zero_data", 64'(log_data[base + 1]), 64'd0);

`ifdef SQRT_ARB_TIMEOUT_EN
        // T6: core never completes, watchdog aborts
        base = hs_n;
        stub_hang = 1'b1;
        issue(1, 32'd81);
        n = 0;
        while (!bus.req_ready[1] && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!bus.rsp_valid && n < TO + 40) begin
            @(negedge clk);
            n++;
        end
        chk("t6_rsp_seen", 64'(bus.rsp_valid), 64'd1);
        chk("t6_core_reset_pulse", 64'(core_reset), 64'd1);
        chk("t6_enable_off", 64'(core_enable), 64'd0);
        chk("t6_window", 64'(n >= TO && n <= TO + 2), 64'd1);
        wait_hs(base + 1, 10, "t6_hs_timeout");
        chk("t6_data", 64'(log_data[base]), 64'hFFFF);
        chk("t6_err", 64'(log_err[base]), 64'd1);
        stub_hang = 1'b0;
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
